// File: rtl/dma_bus_arbiter_if.sv
// Arbitration bundle between DMA masters, the arbiter and the 68SEC000 BR/BG pins.
// The slave modport is the arbiter's view. The master modport is the view of the
// masters and the CPU side.
interface dma_bus_arbiter_if #(
  parameter int NUM_MASTERS = 2
);
  localparam int ID_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  logic                   ENABLE;
  logic                   AS_n;
  logic [NUM_MASTERS-1:0] BR_n;
  logic [NUM_MASTERS-1:0] BGACK_n;
  logic                   CPU_BG_n;
  logic [NUM_MASTERS-1:0] BG_n;
  logic                   CPU_BR_n;
  logic [ID_W-1:0]        GRANT_ID;
  logic                   GRANT_VALID;
  logic                   TIMEOUT_ERR;

  modport slave (
    input  ENABLE, AS_n, BR_n, BGACK_n, CPU_BG_n,
    output BG_n, CPU_BR_n, GRANT_ID, GRANT_VALID, TIMEOUT_ERR
  );

  modport master (
    output ENABLE, AS_n, BR_n, BGACK_n, CPU_BG_n,
    input  BG_n, CPU_BR_n, GRANT_ID, GRANT_VALID, TIMEOUT_ERR
  );
endinterface

// File: rtl/dma_bus_arbiter.sv
// Maps N three-wire (BR/BG/BGACK) DMA masters onto the two-wire BR/BG of the 68SEC000.
// Supports fixed or round-robin priority and a grant-acknowledge timeout.
// A finishing tenure can be handed straight to the next master while the CPU
// still holds BG low.
module dma_bus_arbiter #(
  parameter int NUM_MASTERS   = 2,
  parameter int ROUND_ROBIN   = 0,
  parameter int GRANT_TIMEOUT = 16
) (
  input logic              C7M,
  input logic              RESET,
  dma_bus_arbiter_if.slave bus
);
  localparam int ID_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam logic [7:0] TO_LAST = 8'(GRANT_TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, REQ_CPU, GRANT, OWNED, RELEASE} state_t;

  state_t                 state, state_nx;
  logic [NUM_MASTERS-1:0] req;
  logic [NUM_MASTERS-1:0] bg_n, bg_n_nx;
  logic                   cpu_br_n, cpu_br_n_nx;
  logic                   grant_valid, grant_valid_nx;
  logic                   timeout_err, timeout_err_nx;
  logic [ID_W-1:0]        grant_id, grant_id_nx;
  logic [ID_W-1:0]        rr_ptr, rr_ptr_nx;
  logic [7:0]             cnt, cnt_nx;
  logic [ID_W-1:0]        base, sel, hi_idx, lo_idx;
  logic                   hi_found;
  logic                   bus_free, acked, issue;

  assign req      = ~bus.BR_n;
  assign bus_free = ~bus.CPU_BG_n & bus.AS_n;
  assign acked    = ~bus.BGACK_n[grant_id];
  // rr_ptr holds the index just after the last grantee, so the search begins there.
  assign base     = (ROUND_ROBIN != 0) ? rr_ptr : '0;

  // Priority select: first requester at or above base, else wrap to the lowest requester.
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_idx = ID_W'(i);
        if (ID_W'(i) >= base) begin
          hi_found = 1'b1;
          hi_idx   = ID_W'(i);
        end
      end
    end
    sel = hi_found ? hi_idx : lo_idx;
  end

  // Next-state and next-output logic. A grant can be issued from REQ_CPU or from RELEASE.
  always_comb begin
    state_nx       = state;
    bg_n_nx        = bg_n;
    cpu_br_n_nx    = cpu_br_n;
    grant_valid_nx = grant_valid;
    grant_id_nx    = grant_id;
    rr_ptr_nx      = rr_ptr;
    cnt_nx         = cnt;
    timeout_err_nx = 1'b0;
    issue          = 1'b0;
    case (state)
      IDLE: begin
        if (bus.ENABLE && |req) begin
          cpu_br_n_nx = 1'b0;
          state_nx    = REQ_CPU;
        end
      end
      REQ_CPU: begin
        if (!(|req)) begin
          cpu_br_n_nx = 1'b1;
          state_nx    = IDLE;
        end else if (bus_free) begin
          issue = 1'b1;
        end
      end
      GRANT: begin
        // Only an ack or the timeout ends a grant. A dropped BR is ignored here.
        if (acked) begin
          bg_n_nx  = '1;
          state_nx = OWNED;
        end else if (cnt == TO_LAST) begin
          bg_n_nx        = '1;
          timeout_err_nx = 1'b1;
          grant_valid_nx = 1'b0;
          state_nx       = RELEASE;
        end else begin
          cnt_nx = cnt + 8'd1;
        end
      end
      OWNED: begin
        bg_n_nx = '1;
        if (!acked) begin
          grant_valid_nx = 1'b0;
          state_nx       = RELEASE;
        end
      end
      RELEASE: begin
        if (bus.ENABLE && |req && bus_free) begin
          issue = 1'b1;
        end else if (bus.ENABLE && |req) begin
          state_nx = REQ_CPU;
        end else begin
          cpu_br_n_nx = 1'b1;
          state_nx    = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (issue) begin
      bg_n_nx        = ~(NUM_MASTERS'(1) << sel);
      grant_id_nx    = sel;
      grant_valid_nx = 1'b1;
      cnt_nx         = '0;
      rr_ptr_nx      = (sel == ID_W'(NUM_MASTERS - 1)) ? '0 : sel + 1'b1;
      state_nx       = GRANT;
    end
  end

  // State and registered outputs. A synchronous reset drops any tenure without a handshake.
  always_ff @(posedge C7M) begin
    if (RESET) begin
      state       <= IDLE;
      bg_n        <= '1;
      cpu_br_n    <= 1'b1;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      timeout_err <= 1'b0;
      rr_ptr      <= '0;
      cnt         <= '0;
    end else begin
      state       <= state_nx;
      bg_n        <= bg_n_nx;
      cpu_br_n    <= cpu_br_n_nx;
      grant_valid <= grant_valid_nx;
      grant_id    <= grant_id_nx;
      timeout_err <= timeout_err_nx;
      rr_ptr      <= rr_ptr_nx;
      cnt         <= cnt_nx;
    end
  end

  assign bus.BG_n        = bg_n;
  assign bus.CPU_BR_n    = cpu_br_n;
  assign bus.GRANT_ID    = grant_id;
  assign bus.GRANT_VALID = grant_valid;
  assign bus.TIMEOUT_ERR = timeout_err;
endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Bench for dma_bus_arbiter with two instances:
//   dut_a: 2 masters, fixed priority.
//   dut_b: 4 masters, round-robin.
// A tenure-level model checks both instances every cycle. Directed literal checks
// pin the scenarios.
module tb_dma_bus_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   chk_on = 1'b0;
  int   n_assert = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  dma_bus_arbiter_if #(.NUM_MASTERS(2)) ia ();
  dma_bus_arbiter_if #(.NUM_MASTERS(4)) ib ();

  dma_bus_arbiter #(.NUM_MASTERS(2), .ROUND_ROBIN(0), .GRANT_TIMEOUT(16)) dut_a (
    .C7M(clk), .RESET(rst), .bus(ia.slave));
  dma_bus_arbiter #(.NUM_MASTERS(4), .ROUND_ROBIN(1), .GRANT_TIMEOUT(16)) dut_b (
    .C7M(clk), .RESET(rst), .bus(ib.slave));

  // ---------------- tenure-level model ----------------
  localparam int P_IDLE = 0, P_ASK = 1, P_GRANT = 2, P_OWN = 3, P_REL = 4;
  typedef struct {
    int phase;    // where the bus tenure is
    int owner;    // current or last grantee
    int next;     // round-robin search start
    int waited;   // cycles spent waiting for ack
    bit cpu_req;  // we are asking the CPU for the bus
    bit terr;     // timeout this cycle
  } mdl_t;
  mdl_t ma, mb;

  function automatic int pick(int req, int n, int start);
    for (int k = 0; k < n; k++) begin
      int idx = (start + k) % n;
      if (((req >> idx) & 1) != 0) return idx;
    end
    return 0;
  endfunction

  function automatic mdl_t mnext(input mdl_t m0, input int n, input bit rr, input int to,
                                 input bit r, input bit en, input bit as_n,
                                 input int br_n, input int bgack_n, input bit cpu_bg_n);
    mdl_t m = m0;
    int req = ~br_n & ((1 << n) - 1);
    bit free = !cpu_bg_n && as_n;
    bit oack = ((bgack_n >> m0.owner) & 1) == 0;
    bit give = 1'b0;
    m.terr = 1'b0;
    if (r) begin
      m = '{default: 0};
      return m;
    end
    case (m.phase)
      P_IDLE: if (en && req != 0) begin m.cpu_req = 1'b1; m.phase = P_ASK; end
      P_ASK: begin
        if (req == 0) begin m.cpu_req = 1'b0; m.phase = P_IDLE; end
        else if (free) give = 1'b1;
      end
      P_GRANT: begin
        if (oack) m.phase = P_OWN;
        else begin
          m.waited++;
          if (m.waited == to) begin m.terr = 1'b1; m.phase = P_REL; end
        end
      end
      P_OWN: if (!oack) m.phase = P_REL;
      default: begin
        if (en && req != 0 && free) give = 1'b1;
        else if (en && req != 0) m.phase = P_ASK;
        else begin m.cpu_req = 1'b0; m.phase = P_IDLE; end
      end
    endcase
    if (give) begin
      m.owner  = pick(req, n, rr ? m.next : 0);
      m.next   = (m.owner + 1) % n;
      m.waited = 0;
      m.phase  = P_GRANT;
    end
    return m;
  endfunction

  function automatic int m_bg(mdl_t m, int n);
    return (m.phase == P_GRANT) ? (~(1 << m.owner) & ((1 << n) - 1)) : ((1 << n) - 1);
  endfunction

  function automatic int m_valid(mdl_t m);
    return (m.phase == P_GRANT || m.phase == P_OWN) ? 1 : 0;
  endfunction

  always @(posedge clk) begin
    ma <= mnext(ma, 2, 1'b0, 16, rst, ia.ENABLE, ia.AS_n, 32'(ia.BR_n), 32'(ia.BGACK_n), ia.CPU_BG_n);
    mb <= mnext(mb, 4, 1'b1, 16, rst, ib.ENABLE, ib.AS_n, 32'(ib.BR_n), 32'(ib.BGACK_n), ib.CPU_BG_n);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("a_bg_n",    32'(ia.BG_n),        32'(m_bg(ma, 2)));
      chk("a_cpu_br",  32'(ia.CPU_BR_n),    32'(!ma.cpu_req));
      chk("a_valid",   32'(ia.GRANT_VALID), 32'(m_valid(ma)));
      chk("a_id",      32'(ia.GRANT_ID),    32'(ma.owner));
      chk("a_terr",    32'(ia.TIMEOUT_ERR), 32'(ma.terr));
      chk("b_bg_n",    32'(ib.BG_n),        32'(m_bg(mb, 4)));
      chk("b_cpu_br",  32'(ib.CPU_BR_n),    32'(!mb.cpu_req));
      chk("b_valid",   32'(ib.GRANT_VALID), 32'(m_valid(mb)));
      chk("b_id",      32'(ib.GRANT_ID),    32'(mb.owner));
      chk("b_terr",    32'(ib.TIMEOUT_ERR), 32'(mb.terr));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int low_cnt, pulses, id, wt;
    bit rose;
    int order[5];
    int exp_order[5] = '{0, 1, 2, 3, 0};

    ia.ENABLE = 1'b1; ia.AS_n = 1'b1; ia.BR_n = 2'b11; ia.BGACK_n = 2'b11; ia.CPU_BG_n = 1'b1;
    ib.ENABLE = 1'b1; ib.AS_n = 1'b1; ib.BR_n = 4'hF;  ib.BGACK_n = 4'hF;  ib.CPU_BG_n = 1'b1;
    rst = 1'b1;
    tick();
    chk_on = 1'b1;
    chk("rst_bg_n",  32'(ia.BG_n), 32'h3);
    chk("rst_cpubr", 32'(ia.CPU_BR_n), 32'h1);
    chk("rst_id",    32'(ia.GRANT_ID), 32'h0);
    chk("rst_valid", 32'(ia.GRANT_VALID), 32'h0);
    chk("rst_terr",  32'(ia.TIMEOUT_ERR), 32'h0);
    tick();
    rst = 1'b0;
    tick();

    // Basic single-master tenure, fixed priority.
    ia.BR_n = 2'b10;
    tick(); chk("t1_cpubr_req", 32'(ia.CPU_BR_n), 32'h0);
    tick(); tick();
    chk("t1_no_bg_before_cpu", 32'(ia.BG_n), 32'h3);
    ia.CPU_BG_n = 1'b0;
    tick();
    chk("t1_bg", 32'(ia.BG_n), 32'h2);
    chk("t1_id", 32'(ia.GRANT_ID), 32'h0);
    chk("t1_valid", 32'(ia.GRANT_VALID), 32'h1);
    ia.BGACK_n = 2'b10; ia.BR_n = 2'b11;
    tick(); chk("t1_bg_off", 32'(ia.BG_n), 32'h3);
    tick(); tick(); chk("t1_owned_valid", 32'(ia.GRANT_VALID), 32'h1);
    ia.BGACK_n = 2'b11;
    tick();
    chk("t1_rel_valid", 32'(ia.GRANT_VALID), 32'h0);
    chk("t1_rel_cpubr", 32'(ia.CPU_BR_n), 32'h0);
    tick(); chk("t1_idle_cpubr", 32'(ia.CPU_BR_n), 32'h1);
    ia.CPU_BG_n = 1'b1;
    tick();

    // Grant timeout on master 1. BR is withdrawn during the grant, which must not cancel it.
    ia.BR_n = 2'b01;
    tick(); chk("to_cpubr", 32'(ia.CPU_BR_n), 32'h0);
    ia.CPU_BG_n = 1'b0;
    tick();
    chk("to_bg", 32'(ia.BG_n), 32'h1);
    chk("to_id", 32'(ia.GRANT_ID), 32'h1);
    ia.BR_n = 2'b11;
    low_cnt = 1; pulses = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (!ia.BG_n[1]) low_cnt++;
      if (ia.TIMEOUT_ERR) pulses++;
    end
    chk("to_bg_low_cycles", 32'(low_cnt), 32'd16);
    chk("to_pulses", 32'(pulses), 32'd1);
    chk("to_valid", 32'(ia.GRANT_VALID), 32'h0);
    chk("to_cpubr_idle", 32'(ia.CPU_BR_n), 32'h1);
    chk("to_id_held", 32'(ia.GRANT_ID), 32'h1);
    ia.CPU_BG_n = 1'b1;
    tick();

    // AS_n low holds off the grant. ENABLE drop during OWNED lets the tenure finish, then IDLE.
    ia.BR_n = 2'b10; ia.AS_n = 1'b0;
    tick();
    ia.CPU_BG_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); chk("as_hold_bg", 32'(ia.BG_n), 32'h3);
    end
    ia.AS_n = 1'b1;
    tick(); chk("as_free_bg", 32'(ia.BG_n), 32'h2);
    ia.BGACK_n = 2'b10; ia.BR_n = 2'b01;
    tick();
    ia.ENABLE = 1'b0;
    tick(); tick(); chk("en_owned_valid", 32'(ia.GRANT_VALID), 32'h1);
    ia.BGACK_n = 2'b11;
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      chk("en_off_cpubr", 32'(ia.CPU_BR_n), 32'h1);
      tick();
    end
    ia.BR_n = 2'b11; ia.ENABLE = 1'b1; ia.CPU_BG_n = 1'b1;
    tick();

    // A request withdrawn while waiting for the CPU.
    ia.BR_n = 2'b10;
    tick(); chk("wd_cpubr_req", 32'(ia.CPU_BR_n), 32'h0);
    ia.BR_n = 2'b11;
    tick(); chk("wd_cpubr_drop", 32'(ia.CPU_BR_n), 32'h1);

    // Simultaneous requests, fixed priority: 0 first, then a direct handoff to 1.
    ia.BR_n = 2'b00;
    tick();
    ia.CPU_BG_n = 1'b0;
    tick();
    chk("sim_bg0", 32'(ia.BG_n), 32'h2);
    chk("sim_id0", 32'(ia.GRANT_ID), 32'h0);
    ia.BGACK_n = 2'b10; ia.BR_n = 2'b01;
    tick();
    ia.BGACK_n = 2'b11;
    tick(); tick();
    chk("sim_bg1", 32'(ia.BG_n), 32'h1);
    chk("sim_id1", 32'(ia.GRANT_ID), 32'h1);
    chk("sim_cpubr", 32'(ia.CPU_BR_n), 32'h0);
    ia.BGACK_n = 2'b01; ia.BR_n = 2'b11;
    tick();
    ia.BGACK_n = 2'b11;
    tick(); tick();
    ia.CPU_BG_n = 1'b1;
    chk("sim_idle", 32'(ia.CPU_BR_n), 32'h1);
    tick();

    // Reset while master 1 owns the bus.
    ia.BR_n = 2'b01;
    tick();
    ia.CPU_BG_n = 1'b0;
    tick(); chk("rs_id", 32'(ia.GRANT_ID), 32'h1);
    ia.BGACK_n = 2'b01;
    tick(); chk("rs_owned_valid", 32'(ia.GRANT_VALID), 32'h1);
    rst = 1'b1;
    tick();
    chk("rs_bg", 32'(ia.BG_n), 32'h3);
    chk("rs_cpubr", 32'(ia.CPU_BR_n), 32'h1);
    chk("rs_valid", 32'(ia.GRANT_VALID), 32'h0);
    chk("rs_id0", 32'(ia.GRANT_ID), 32'h0);
    rst = 1'b0; ia.BGACK_n = 2'b11; ia.BR_n = 2'b11; ia.CPU_BG_n = 1'b1;
    tick();

    // Round robin over 4 masters all requesting: expect order 0,1,2,3,0 with no CPU_BR_n rise.
    ib.BR_n = 4'h0;
    tick();
    ib.CPU_BG_n = 1'b0;
    rose = 1'b0;
    for (int g = 0; g < 5; g++) begin
      wt = 0;
      while (ib.BG_n == 4'hF && wt < 10) begin
        tick(); wt++;
        if (ib.CPU_BR_n) rose = 1'b1;
      end
      chk("rr_grant_seen", 32'(wt < 10), 32'h1);
      id = 0;
      for (int k = 3; k >= 0; k--) if (!ib.BG_n[k]) id = k;
      order[g] = id;
      ib.BGACK_n = ~(4'b0001 << id);
      tick();
      tick();
      if (g == 4) ib.BR_n = 4'hF;
      ib.BGACK_n = 4'hF;
      tick();
      if (ib.CPU_BR_n) rose = 1'b1;
    end
    for (int g = 0; g < 5; g++) chk($sformatf("rr_order_%0d", g), 32'(order[g]), 32'(exp_order[g]));
    chk("rr_no_cpubr_rise", 32'(rose), 32'h0);
    tick(); chk("rr_idle_cpubr", 32'(ib.CPU_BR_n), 32'h1);
    ib.CPU_BG_n = 1'b1;
    tick(); tick();

    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
